// File: rtl/cuenta_reg_escritura_pkg.sv
// Shared definitions for the register write/read sequencing counters:
// default timing parameters, field widths, FSM encoding and the wr window helper.
package cuenta_reg_escritura_pkg;

  localparam int N_REG_DEF  = 9;
  localparam int T_SLOT_DEF = 180;
  localparam int WR_ON_DEF  = 10;
  localparam int WR_OFF_DEF = 170;

  localparam int DIR_W  = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SLOT = 2'd1,
    S_DONE = 2'd2
  } estado_t;

  // True when the tick count lies inside the inclusive [lo, hi] strobe window.
  function automatic logic en_ventana(input logic [CNT_W-1:0] cnt,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/banco_reg_escritura.sv
// Staging bank: N_REG x 8-bit storage with one synchronous write port,
// one combinational read port and a synchronous clear on reset.
module banco_reg_escritura
  import cuenta_reg_escritura_pkg::*;
#(
  parameter int N_REG = N_REG_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [DIR_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DIR_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam logic [DIR_W-1:0] N_REG_W = DIR_W'(N_REG);

  logic [DATA_W-1:0] mem_q [N_REG];

  // Clear every entry on reset; otherwise accept in-range writes only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_REG; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (we_i && (wr_addr_i < N_REG_W)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Combinational read; out-of-range addresses return zero rather than X.
  always_comb begin
    rd_data_o = 8'h00;
    if (rd_addr_i < N_REG_W) begin
      rd_data_o = mem_q[rd_addr_i];
    end else begin
      rd_data_o = 8'h00;
    end
  end

endmodule

// File: rtl/cuenta_reg_escritura.sv
// Write-sequence counter: walks register addresses 0..N_REG-1, spending
// T_SLOT+1 cycles on each, and raises wr during the [WR_ON, WR_OFF] ticks
// of every slot. The data for each address comes from a staging bank that
// can only be loaded while no sequence is running.
module cuenta_reg_escritura
  import cuenta_reg_escritura_pkg::*;
#(
  parameter int N_REG  = N_REG_DEF,
  parameter int T_SLOT = T_SLOT_DEF,
  parameter int WR_ON  = WR_ON_DEF,
  parameter int WR_OFF = WR_OFF_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              En,
  input  logic              start,
  input  logic              load,
  input  logic [DIR_W-1:0]  load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DIR_W-1:0]  dir,
  output logic [DATA_W-1:0] dato,
  output logic              wr,
  output logic [CNT_W-1:0]  salida,
  output logic              busy,
  output logic              done
);

  localparam logic [DIR_W-1:0] N_REG_W   = DIR_W'(N_REG);
  localparam logic [DIR_W-1:0] LAST_DIR  = DIR_W'(N_REG - 1);
  localparam logic [CNT_W-1:0] T_SLOT_W  = CNT_W'(T_SLOT);
  localparam logic [CNT_W-1:0] WR_ON_W   = CNT_W'(WR_ON);
  localparam logic [CNT_W-1:0] WR_OFF_W  = CNT_W'(WR_OFF);

  estado_t           state_q,  state_d;
  logic [CNT_W-1:0]  salida_q, salida_d;
  logic [DIR_W-1:0]  dir_q,    dir_d;
  logic              wr_q,     wr_d;
  logic              busy_q,   busy_d;
  logic              done_q,   done_d;
  logic              load_ok_s;

  // The bank is frozen while a sequence runs so the data under dir stays stable.
  assign load_ok_s = load && (state_q != S_SLOT) && (load_addr < N_REG_W);

  banco_reg_escritura #(
    .N_REG (N_REG)
  ) u_banco (
    .clk       (clk),
    .reset     (reset),
    .we_i      (load_ok_s),
    .wr_addr_i (load_addr),
    .wr_data_i (load_data),
    .rd_addr_i (dir_q),
    .rd_data_o (dato)
  );

  // Next-state and next-output logic; En low collapses everything to IDLE.
  always_comb begin
    state_d  = state_q;
    salida_d = salida_q;
    dir_d    = dir_q;
    if (!En) begin
      state_d  = S_IDLE;
      salida_d = 8'd0;
      dir_d    = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          salida_d = 8'd0;
          dir_d    = 4'd0;
          if (start) begin
            state_d = S_SLOT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SLOT: begin
          if (salida_q == T_SLOT_W) begin
            salida_d = 8'd0;
            if (dir_q == LAST_DIR) begin
              state_d = S_DONE;
              dir_d   = 4'd0;
            end else begin
              state_d = S_SLOT;
              dir_d   = dir_q + 4'd1;
            end
          end else begin
            state_d  = S_SLOT;
            salida_d = salida_q + 8'd1;
          end
        end
        S_DONE: begin
          // Start requests here are deliberately dropped.
          state_d  = S_IDLE;
          salida_d = 8'd0;
          dir_d    = 4'd0;
        end
        default: begin
          state_d  = S_IDLE;
          salida_d = 8'd0;
          dir_d    = 4'd0;
        end
      endcase
    end
    busy_d = (state_d == S_SLOT);
    done_d = (state_d == S_DONE);
    wr_d   = busy_d && en_ventana(salida_d, WR_ON_W, WR_OFF_W);
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      salida_q <= 8'd0;
      dir_q    <= 4'd0;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      salida_q <= salida_d;
      dir_q    <= dir_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dir    = dir_q;
  assign salida = salida_q;
  assign wr     = wr_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_cuenta_reg_escritura.sv
// Self-checking bench for cuenta_reg_escritura: a timeline reference model
// (cycles elapsed since start, divided into slots) predicts every output
// after each rising edge; a monitor compares on the falling edge.
module tb_cuenta_reg_escritura;

  localparam int N_REG    = 9;
  localparam int T_SLOT   = 180;
  localparam int WR_ON    = 10;
  localparam int WR_OFF   = 170;
  localparam int SLOT_LEN = T_SLOT + 1;
  localparam int SEQ_LEN  = N_REG * SLOT_LEN;

  logic       clk = 1'b0;
  logic       reset, En, start, load;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [3:0] dir;
  logic [7:0] dato;
  logic       wr;
  logic [7:0] salida;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  cuenta_reg_escritura #(
    .N_REG  (N_REG),
    .T_SLOT (T_SLOT),
    .WR_ON  (WR_ON),
    .WR_OFF (WR_OFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .En        (En),
    .start     (start),
    .load      (load),
    .load_addr (load_addr),
    .load_data (load_data),
    .dir       (dir),
    .dato      (dato),
    .wr        (wr),
    .salida    (salida),
    .busy      (busy),
    .done      (done)
  );

  typedef struct packed {
    logic [3:0] dir;
    logic [7:0] dato;
    logic       wr;
    logic [7:0] salida;
    logic       busy;
    logic       done;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_done_n = 0;
  int got_done_n = 0;

  // Reference model: active flag, elapsed cycles t since the start edge, done flag, bank image.
  bit         m_active = 1'b0;
  int         m_t = 0;
  bit         m_done = 1'b0;
  logic [7:0] m_bank [N_REG];

  task automatic step(input logic r, input logic en, input logic st,
                      input logic ld, input logic [3:0] la, input logic [7:0] d);
    snap_t e;
    bit was_active;
    int dv, sv;
    @(negedge clk);
    reset = r; En = en; start = st; load = ld; load_addr = la; load_data = d;
    @(posedge clk);
    was_active = m_active;
    if (r) begin
      m_active = 1'b0; m_t = 0; m_done = 1'b0;
      for (int i = 0; i < N_REG; i++) m_bank[i] = 8'h00;
    end else begin
      if (!was_active && ld && (int'(la) < N_REG)) m_bank[la] = d;
      if (!en) begin
        m_active = 1'b0; m_t = 0; m_done = 1'b0;
      end else if (m_active) begin
        m_t = m_t + 1;
        if (m_t == SEQ_LEN) begin
          m_active = 1'b0; m_t = 0; m_done = 1'b1;
          exp_done_n++;
        end
      end else if (m_done) begin
        m_done = 1'b0;
      end else if (st) begin
        m_active = 1'b1; m_t = 0;
      end
    end
    dv = m_active ? (m_t / SLOT_LEN) : 0;
    sv = m_active ? (m_t % SLOT_LEN) : 0;
    e.dir    = 4'(dv);
    e.salida = 8'(sv);
    e.dato   = m_bank[dv];
    e.wr     = m_active && (sv >= WR_ON) && (sv <= WR_OFF);
    e.busy   = m_active;
    e.done   = m_done;
    exp_q.push_back(e);
  endtask

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  // Monitor: one expected snapshot per rising edge, checked on the falling edge.
  initial begin : monitor
    snap_t e, g;
    forever begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) got_done_n++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g.dir = dir; g.dato = dato; g.wr = wr; g.salida = salida; g.busy = busy; g.done = done;
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL snapshot cyc=%0d got dir=%0d dato=%02h wr=%0b salida=%0d busy=%0b done=%0b | expected dir=%0d dato=%02h wr=%0b salida=%0d busy=%0b done=%0b",
                   cyc, g.dir, g.dato, g.wr, g.salida, g.busy, g.done,
                   e.dir, e.dato, e.wr, e.salida, e.busy, e.done);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0; En = 1'b0; start = 1'b0; load = 1'b0; load_addr = 4'd0; load_data = 8'h00;
    for (int i = 0; i < N_REG; i++) m_bank[i] = 8'h00;

    // Reset for two cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

    // Fresh bank must read zero everywhere: run one sequence over it.
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00);
    run_idle(SEQ_LEN + 1);

    // Load 0x10..0x18, then out-of-range addresses that must be ignored.
    for (int i = 0; i < N_REG; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 4'(i), 8'(16 + i));
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd9, 8'h55);
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 8'h66);

    // Full sequence with start+load attempted mid-run, and start sampled in DONE.
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00);
    run_idle(400);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 8'hAA);
    run_idle(SEQ_LEN - 401);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00);
    run_idle(3);

    // Simultaneous load and start in IDLE; bank[2] still holds 0x12.
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd8, 8'h5A);
    run_idle(SEQ_LEN + 2);

    // Abort: En drops while dir=4, salida=50; start with En low is ignored.
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00);
    run_idle(4 * SLOT_LEN + 50);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00);
    run_idle(3);

    // Reset mid-sequence at dir=6, then a full run over the cleared bank.
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00);
    run_idle(6 * SLOT_LEN + 20);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 8'h77);
    run_idle(2);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00);
    run_idle(SEQ_LEN + 2);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom_range(0, 499) == 0),
           1'($urandom_range(0, 63) != 0),
           1'($urandom_range(0, 149) == 0),
           1'($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)),
           8'($urandom));
    end
    run_idle(SEQ_LEN + 2);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d expected pending=0", exp_q.size());
    end
    checks++;
    if (got_done_n != exp_done_n) begin
      errors++;
      $display("FAIL done_count got=%0d expected=%0d", got_done_n, exp_done_n);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cuenta_reg_escritura.md
CUENTA_REG_ESCRITURA -- requirements
Module: cuenta_reg_escritura

Interface
REQ-001 Parameter N_REG, default 9, number of registers written per sequence (addresses 0..N_REG-1).
REQ-002 Parameter T_SLOT, default 180, last tick value of each address slot (slot length T_SLOT+1 cycles).
REQ-003 Parameter WR_ON, default 10, first tick of the slot with wr high.
REQ-004 Parameter WR_OFF, default 170, last tick of the slot with wr high.
REQ-005 clk  input  1  system clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-007 En  input  1  block enable; low forces IDLE.
REQ-008 start  input  1  one-cycle request to begin a write sequence.
REQ-009 load  input  1  write load_data into the staging bank at load_addr.
REQ-010 load_addr  input  4  staging bank address.
REQ-011 load_data  input  8  staging bank data.
REQ-012 dir  output  4  register address currently being written.
REQ-013 dato  output  8  staging bank content at dir.
REQ-014 wr  output  1  write strobe toward the register interface.
REQ-015 salida  output  8  current tick within the slot.
REQ-016 busy  output  1  high while a sequence is in progress.
REQ-017 done  output  1  one-cycle pulse at sequence completion.

Function
REQ-018 The FSM SHALL have states IDLE, SLOT and DONE.
REQ-019 IDLE: salida=0, dir=0, wr=0, busy=0; with En=1 and start=1 sampled, the next state SHALL be SLOT with salida=0 and dir=0.
REQ-020 SLOT: salida SHALL increment by 1 per cycle from 0 to T_SLOT, then wrap to 0 with dir+1.
REQ-021 SLOT with dir=N_REG-1 and salida=T_SLOT: the next state SHALL be DONE; dir SHALL NOT exceed N_REG-1.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 wr SHALL be high only in SLOT when WR_ON <= salida <= WR_OFF (registered, no glitches).
REQ-024 busy SHALL be high only in SLOT.
REQ-025 dato SHALL equal bank[dir] combinationally.
REQ-026 A full sequence SHALL occupy N_REG*(T_SLOT+1) cycles in SLOT (1629 at defaults).
REQ-027 load SHALL write the bank only when busy=0 and load_addr < N_REG; otherwise it is ignored.
REQ-028 start while busy=1 or in DONE SHALL be ignored.
REQ-029 En=0 in any state SHALL force IDLE next cycle: salida=0, dir=0, wr=0, no done; bank contents are kept.
REQ-030 Simultaneous load and start in IDLE: the load SHALL take effect and the sequence SHALL start.
REQ-031 Counter arithmetic SHALL be 8-bit for salida and 4-bit for dir, without overflow at legal parameter values.

Reset
REQ-032 reset=1 SHALL, at the next rising edge of clk, force IDLE with salida=0, dir=0, wr=0, busy=0, done=0 and the bank cleared to 0x00.
REQ-033 reset SHALL take priority over En, start and load, including mid-sequence.

Structure
REQ-034 N_REG, T_SLOT, WR_ON, WR_OFF defaults and the FSM state encoding SHALL reside in a shared package used with the read counter.
REQ-035 The staging bank SHALL be a sub-module banco_reg_escritura (N_REG x 8 bits, one synchronous write port, one combinational read port).

Verification
REQ-036 Reset: assert reset for 2 cycles -> all outputs 0 and bank reads 0x00 at every address.
REQ-037 Full sequence: load 0x10..0x18 at addresses 0..8, pulse start -> dir steps 0..8, dato 0x10..0x18, 9 wr pulses of 161 cycles each, done high once 1629 cycles after the start edge.
REQ-038 Abort: drop En at dir=4, salida=50 -> next cycle wr=0, dir=0, salida=0, no done pulse.
REQ-039 Protection: start and load(addr 2, 0xAA) during busy -> sequence unchanged, bank[2] unchanged; load at addr 9 or 15 in IDLE -> ignored.
REQ-040 Reset at dir=6 -> IDLE next cycle with bank cleared; a new start then runs a full 1629-cycle sequence writing 0x00.
